// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, requester IDs and counter sizing for the memory port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;
  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter that flags the last cycle of a fixed-latency access.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - W'(1);
  assign done = count == W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the IF and MEM stages, data side first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int INST_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INST_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = cnt_w(MEM_LAT);
  state_t state, next;
  logic load, done, gnt_id, we_q, if_go, dm_go, if_cap, dm_cap;
  // a requester still seeing its valid this cycle is not re-granted
  assign if_go = if_req & ~if_valid;
  assign dm_go = dm_req & ~dm_valid;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;
  assign if_cap = (state == BUSY_IF) & done;
  assign dm_cap = (state == BUSY_DM) & done;
  mem_lat_counter #(.W(CW)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .value(CW'(MEM_LAT)), .done(done)
  );
  always_comb begin
    next = state;
    load = 1'b0;
    gnt_id = dm_go ? REQ_DM : REQ_IF;
    if (state == IDLE) begin
      load = dm_go | if_go;
      next = dm_go ? BUSY_DM : if_go ? BUSY_IF : IDLE;
    end else if (done) next = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      we_q <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
    end else begin
      mem_en <= load;
      mem_we <= load & (gnt_id == REQ_DM) & dm_we;
      if (load) begin
        mem_addr <= (gnt_id == REQ_DM) ? dm_addr : if_addr;
        mem_wdata <= (gnt_id == REQ_DM) ? dm_wdata : mem_wdata;
        we_q <= (gnt_id == REQ_DM) & dm_we;
      end
      // flushed fetches and loads are dropped; an issued store still completes
      if_valid <= if_cap & if_req;
      dm_valid <= dm_cap & (dm_req | we_q);
      if (if_cap && if_req) if_rdata <= mem_addr[2] ? mem_rdata[2*INST_W-1:INST_W] : mem_rdata[INST_W-1:0];
      if (dm_cap && dm_req && !we_q) dm_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared IF/MEM memory port arbiter with MEM_LAT = 2.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 0;
  logic        if_req = 0, if_valid, if_stall;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        dm_req = 0, dm_we = 0, dm_valid, dm_stall;
  logic [63:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [63:0] wr_mem [64];
  logic        wr_vld [64] = '{default: 1'b0};
  logic [63:0] dq[$];
  logic [31:0] iq[$];
  logic [31:0] last_if;
  int edge_cnt = 0, n_checks = 0, n_fail = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .INST_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic logic [63:0] rd(input int idx);
    if (wr_vld[idx]) return wr_mem[idx];
    if (idx == 0) return 64'h00500093_00000013;
    if (idx == 32) return 64'h11223344_55667788;
    return {8{8'(idx)}} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  function automatic logic [31:0] fw(input logic [63:0] a);
    logic [63:0] w;
    w = rd(int'(a[8:3]));
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  // memory model: data is only meaningful in the cycle the arbiter must capture it
  always @(posedge clk) begin : model
    logic en_d, we_d;
    logic [63:0] a_d, w_d;
    en_d = mem_en; we_d = mem_we; a_d = mem_addr; w_d = mem_wdata;
    #1;
    if (en_d && we_d) begin
      wr_mem[a_d[8:3]] = w_d;
      wr_vld[a_d[8:3]] = 1'b1;
    end
    mem_rdata = (en_d && !we_d) ? rd(int'(a_d[8:3])) : 64'hBADC0FFE_E0DDF00D;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic wait_valid(input bit is_if, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (is_if ? if_valid : dm_valid) begin
        at = edge_cnt;
        break;
      end
    end
  endtask

  task automatic test_reset;
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 64'h100; if_addr = 64'h0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_regs: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid});
      end
      n_checks++;
      if ({if_stall, dm_stall} !== 2'b11) begin
        n_fail++;
        $display("FAIL reset_stall: got %b want 11", {if_stall, dm_stall});
      end
    end
    reset = 1;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h100}) begin
      n_fail++;
      $display("FAIL reset_release_grant: got en=%b we=%b addr=%h want en=1 we=0 addr=100", mem_en, mem_we, mem_addr);
    end
    if_req = 0; dm_req = 0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({if_valid, dm_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_flushed_load: got valids %b want 00", {if_valid, dm_valid});
      end
    end
  endtask

  task automatic test_fetch;
    logic [31:0] e;
    int n;
    @(negedge clk);
    if_req = 1; if_addr = 64'h4; iq.push_back(32'h00500093); n = edge_cnt + 1;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h4}) begin
      n_fail++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=4", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, if_stall, if_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL fetch_wait: got en/stall/valid=%b want 010", {mem_en, if_stall, if_valid});
    end
    @(negedge clk);
    e = iq.pop_front();
    n_checks++;
    if ({if_valid, if_stall, if_rdata} !== {1'b1, 1'b0, e} || edge_cnt != n + 2) begin
      n_fail++;
      $display("FAIL fetch_done: got valid=%b stall=%b data=%h edge=%0d want valid=1 stall=0 data=%h edge=%0d",
               if_valid, if_stall, if_rdata, edge_cnt, e, n + 2);
    end
    if_req = 0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse: got if_valid=%b want 0", if_valid);
    end
    last_if = e;
  endtask

  task automatic test_simul;
    logic [63:0] d;
    logic [31:0] e;
    int n, at;
    if_req = 1; if_addr = 64'h0; dm_req = 1; dm_we = 0; dm_addr = 64'h100;
    dq.push_back(rd(32)); iq.push_back(fw(64'h0)); n = edge_cnt + 1;
    wait_valid(0, at);
    d = dq.pop_front();
    n_checks++;
    if (dm_rdata !== d || at != n + 2) begin
      n_fail++;
      $display("FAIL simul_dm: got data=%h edge=%0d want data=%h edge=%0d", dm_rdata, at, d, n + 2);
    end
    dm_req = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL simul_if_grant: got en=%b addr=%h want en=1 addr=0", mem_en, mem_addr);
    end
    wait_valid(1, at);
    e = iq.pop_front();
    n_checks++;
    if (if_rdata !== e || at != n + 5) begin
      n_fail++;
      $display("FAIL simul_if: got data=%h edge=%0d want data=%h edge=%0d", if_rdata, at, e, n + 5);
    end
    if_req = 0;
    last_if = e;
  endtask

  task automatic test_store;
    dm_req = 1; dm_we = 1; dm_addr = 64'h10; dm_wdata = 64'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 64'h10, 64'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h want en=1 we=1 addr=10 wdata=deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_one_cycle: got en/we=%b want 00", {mem_en, mem_we});
    end
    @(negedge clk);
    n_checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, 64'h11223344_55667788}) begin
      n_fail++;
      $display("FAIL store_done: got valid=%b rdata=%h want valid=1 rdata=1122334455667788", dm_valid, dm_rdata);
    end
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    n_checks++;
    if (dm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_pulse: got dm_valid=%b want 0", dm_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, d;
    logic [31:0] e;
    int n, at;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 64'h10 : {55'd0, 6'($urandom_range(0, 63)), 3'd0};
      if (i[0] && $urandom_range(0, 1) == 1) a[2] = 1'b1;
      if (i[0]) begin
        if_req = 1; if_addr = a; iq.push_back(fw(a));
      end else begin
        dm_req = 1; dm_we = 0; dm_addr = a;
        dq.push_back(i == 0 ? 64'hDEADBEEF : rd(int'(a[8:3])));
      end
      n = edge_cnt + 1;
      wait_valid(i[0], at);
      if (i[0]) begin
        e = iq.pop_front();
        if_req = 0;
        n_checks++;
        if (if_rdata !== e || at != n + 2) begin
          n_fail++;
          $display("FAIL b2b_if[%0d]: got data=%h edge=%0d want data=%h edge=%0d", i, if_rdata, at, e, n + 2);
        end
        last_if = e;
      end else begin
        d = dq.pop_front();
        dm_req = 0;
        n_checks++;
        if (dm_rdata !== d || at != n + 2) begin
          n_fail++;
          $display("FAIL b2b_dm[%0d]: got data=%h edge=%0d want data=%h edge=%0d", i, dm_rdata, at, d, n + 2);
        end
      end
    end
  endtask

  task automatic test_flush;
    logic [63:0] d;
    int n, at;
    @(negedge clk);
    if_req = 1; if_addr = 64'h4; n = edge_cnt + 1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_issue: got mem_en=%b want 1", mem_en);
    end
    if_req = 0;
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 64'h100; dq.push_back(rd(32));
    @(negedge clk);
    n_checks++;
    if ({if_valid, mem_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_dropped: got if_valid/mem_en=%b want 00", {if_valid, mem_en});
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 64'h100} || edge_cnt != n + 3) begin
      n_fail++;
      $display("FAIL flush_next_grant: got en=%b addr=%h edge=%0d want en=1 addr=100 edge=%0d", mem_en, mem_addr, edge_cnt, n + 3);
    end
    wait_valid(0, at);
    d = dq.pop_front();
    dm_req = 0;
    n_checks++;
    if (dm_rdata !== d || at != n + 5 || if_rdata !== last_if) begin
      n_fail++;
      $display("FAIL flush_followup: got dm=%h edge=%0d if_rdata=%h want dm=%h edge=%0d if_rdata=%h",
               dm_rdata, at, if_rdata, d, n + 5, last_if);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    int n, at;
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 64'h18; n = edge_cnt + 1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_issue: got mem_en=%b want 1", mem_en);
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid});
    end
    @(negedge clk);
    n_checks++;
    if (dm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_valid: got dm_valid=%b want 0", dm_valid);
    end
    reset = 1;
    dq.push_back(rd(3));
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 64'h18}) begin
      n_fail++;
      $display("FAIL mid_regrant: got en=%b addr=%h want en=1 addr=18", mem_en, mem_addr);
    end
    wait_valid(0, at);
    d = dq.pop_front();
    dm_req = 0;
    n_checks++;
    if (dm_rdata !== d || at != n + 5) begin
      n_fail++;
      $display("FAIL mid_fresh_load: got data=%h edge=%0d want data=%h edge=%0d", dm_rdata, at, d, n + 5);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_simul;
    test_store;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
